// File: rtl/rc4_message_readout_if.sv
// rtl/rc4_message_readout_if.sv - byte stream from the message readout toward the display/UART sink
interface rc4_message_readout_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rc4_message_readout.sv
// rtl/rc4_message_readout.sv - latches the RC4 search result and streams the decrypted message from d_mem
module rc4_message_readout #(
  parameter int MSG_LEN    = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  key_found,
  input  logic [23:0]           secret_key,
  output logic [ADDR_WIDTH-1:0] d_mem_addr,
  input  logic [7:0]            d_mem_data_out,
  rc4_message_readout_if.master out_if,
  output logic [23:0]           key_out,
  output logic                  busy,
  output logic                  done,
  output logic                  msg_ok
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MSG_LEN - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  start_d;
  logic                  start_rise;
  logic                  byte_ok;

  assign start_rise = start && !start_d;
  assign byte_ok    = (d_mem_data_out == 8'h20) ||
                      ((d_mem_data_out >= 8'h61) && (d_mem_data_out <= 8'h7A));

  // start_d comes out of reset high so a done flag already up at reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      start_d          <= 1'b1;
      idx              <= '0;
      d_mem_addr       <= '0;
      out_if.out_data  <= 8'h00;
      out_if.out_valid <= 1'b0;
      key_out          <= 24'h000000;
      busy             <= 1'b0;
      done             <= 1'b0;
      msg_ok           <= 1'b0;
    end else begin
      start_d <= start;
      case (state)
        IDLE: begin
          if (start_rise) begin
            key_out <= secret_key;
            if (key_found) begin
              idx        <= '0;
              d_mem_addr <= '0;
              msg_ok     <= 1'b1;
              busy       <= 1'b1;
              state      <= READ;
            end else begin
              msg_ok <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          out_if.out_data  <= d_mem_data_out;
          out_if.out_valid <= 1'b1;
          if (!byte_ok) msg_ok <= 1'b0;
          state <= SEND;
        end
        SEND: begin
          if (out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx        <= idx + 1'b1;
              d_mem_addr <= idx + 1'b1;
              state      <= READ;
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_message_readout.sv
// tb/tb_rc4_message_readout.sv - scoreboard bench for rc4_message_readout
module tb_rc4_message_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        key_found;
  logic [23:0] secret_key;
  logic [7:0]  d_mem_addr;
  logic [7:0]  d_mem_data_out;
  logic [23:0] key_out;
  logic        busy;
  logic        done;
  logic        msg_ok;

  rc4_message_readout_if out_if ();

  rc4_message_readout #(.MSG_LEN(32), .ADDR_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .key_found      (key_found),
    .secret_key     (secret_key),
    .d_mem_addr     (d_mem_addr),
    .d_mem_data_out (d_mem_data_out),
    .out_if         (out_if.master),
    .key_out        (key_out),
    .busy           (busy),
    .done           (done),
    .msg_ok         (msg_ok)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  always @(posedge clk) d_mem_data_out <= mem[d_mem_addr[4:0]];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid_held", {31'd0, out_if.out_valid}, 32'd1);
      check("stall_data_held", {24'd0, out_if.out_data}, {24'd0, prev_data});
    end
    prev_stall = out_if.out_valid && !out_if.out_ready && !reset;
    prev_data  = out_if.out_data;
    if (out_if.out_valid && out_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", out_if.out_data);
      end else begin
        check("byte", {24'd0, out_if.out_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
    end
  end

  task automatic load_msg();
    string s;
    s = "the quick brown fox jumps over a";
    for (int i = 0; i < 32; i++) mem[i] = s[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_run(input string tag, input logic kf, input logic [23:0] key, input logic stall,
                        input int exp_first, input int exp_done, input logic exp_ok);
    int   first_n = 0;
    int   done_n = 0;
    int   b4_n = 0;
    int   rises = 0;
    logic prev_v = 1'b0;
    logic busy_seen = 1'b0;
    if (kf) for (int i = 0; i < 32; i++) exp_q.push_back(mem[i]);
    @(negedge clk);
    start = 1'b1;
    key_found = kf;
    secret_key = key;
    @(posedge clk);
    #1;
    key_found = ~kf;
    secret_key = 24'h123456;
    for (int n = 1; n <= 400; n++) begin
      if (stall && n == 12) out_if.out_ready = 1'b0;
      if (stall && n == 17) out_if.out_ready = 1'b1;
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (out_if.out_valid && !prev_v) begin
        rises++;
        if (rises == 1) first_n = n;
        if (rises == 5) b4_n = n;
      end
      prev_v = out_if.out_valid;
      if (done && done_n == 0) done_n = n;
      if (done_n != 0 && n >= done_n + 2) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_first_valid"}, first_n, exp_first);
    check({tag, "_done_latency"}, done_n, exp_done);
    check({tag, "_msg_ok"}, {31'd0, msg_ok}, {31'd0, exp_ok});
    check({tag, "_key_out"}, {8'd0, key_out}, {8'd0, key});
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({tag, "_byte_count"}, rises, kf ? 32 : 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    if (!kf) check({tag, "_busy_never"}, {31'd0, busy_seen}, 32'd0);
    if (stall) check({tag, "_byte4_after_stall"}, b4_n, 20);
  endtask

  initial begin
    int stuck;
    reset = 1'b1;
    start = 1'b0;
    key_found = 1'b0;
    secret_key = 24'h000000;
    out_if.out_ready = 1'b1;
    load_msg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_if.out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {24'd0, d_mem_addr}, 32'd0);
    check("rst_key", {8'd0, key_out}, 32'd0);
    check("rst_msg_ok", {31'd0, msg_ok}, 32'd0);
    reset = 1'b0;

    do_run("normal", 1'b1, 24'h000249, 1'b0, 3, 97, 1'b1);

    // Start stays high well after done: no second readout.
    stuck = 0;
    repeat (200) begin
      @(negedge clk);
      if (!done || busy) stuck++;
    end
    check("hold_start_done_stays", stuck, 0);

    do_reset();
    do_run("stall", 1'b1, 24'h000249, 1'b1, 3, 102, 1'b1);

    do_reset();
    do_run("no_key", 1'b0, 24'h3FFFFF, 1'b0, 0, 1, 1'b0);

    do_reset();
    mem[17] = 8'h41;
    do_run("bad17", 1'b1, 24'h000249, 1'b0, 3, 97, 1'b0);
    load_msg();

    do_reset();
    mem[31] = 8'h7B;
    do_run("bad31", 1'b1, 24'h000249, 1'b0, 3, 97, 1'b0);
    load_msg();

    // Asynchronous reset while byte 10 is being presented.
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(mem[i]);
    @(negedge clk);
    start = 1'b1;
    key_found = 1'b1;
    secret_key = 24'h000249;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #3;
    check("pre_reset_valid", {31'd0, out_if.out_valid}, 32'd1);
    check("pre_reset_byte10", {24'd0, out_if.out_data}, {24'd0, mem[10]});
    reset = 1'b1;
    #1;
    check("async_valid", {31'd0, out_if.out_valid}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_key", {8'd0, key_out}, 32'd0);
    check("async_msg_ok", {31'd0, msg_ok}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    stuck = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || out_if.out_valid) stuck++;
    end
    check("no_retrigger_after_reset", stuck, 0);
    start = 1'b0;
    @(posedge clk);
    do_run("restart", 1'b1, 24'h000249, 1'b0, 3, 97, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
